// File: rtl/pri_enc_pkg.sv
// Purpose : shared widths, counter size and collector FSM states for the priority-request path.
// Latency : n/a (declarations only).
// Backpr. : n/a.
package pri_enc_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESENT  = 2'd1,
        WAIT_ENC = 2'd2,
        WAIT_ACK = 2'd3
    } state_e;

    // One-hot mask selecting a single request line.
    function automatic logic [N_REQ-1:0] line_bit(input logic [IDX_W-1:0] i);
        return N_REQ'(1) << i;
    endfunction

endpackage

// File: rtl/pri_req_sync.sv
// Purpose : two-flop synchronizer for the raw request lines.
// Latency : 2 cycles.
// Backpr. : none; samples every cycle.
module pri_req_sync
    import pri_enc_pkg::*;
#(
    parameter int W = N_REQ
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] s1_q, s1_d;
    logic [W-1:0] s2_q, s2_d;

    // Shift each stage forward by one cycle.
    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    // Both stages clear on reset so a held-high input is seen as a fresh edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/pri_req_collector.sv
// Purpose : edge-collects 8 request lines, presents a masked snapshot to an external encoder, grants one line at a time.
// Latency : 4 cycles request edge -> grant_vld; +2 when PRI_REQ_SYNC_EN inserts the input synchronizer.
// Backpr. : grant held until ack or ACK_TIMEOUT (1..255); edges keep accumulating in pending, repeats raise sticky ovf.
module pri_req_collector
    import pri_enc_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] mask,
    output logic [N_REQ-1:0] a,
    output logic             vin,
    input  logic [IDX_W-1:0] idx,
    output logic             grant_vld,
    output logic [IDX_W-1:0] grant_idx,
    input  logic             ack,
    output logic             timeout,
    output logic [N_REQ-1:0] ovf,
    input  logic             ovf_clr
);

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(ACK_TIMEOUT);

    logic [N_REQ-1:0] req_s;
    logic [N_REQ-1:0] req_prev_q, req_prev_d;
    logic [N_REQ-1:0] edge_vec;
    logic [N_REQ-1:0] pending_q, pending_d;
    logic [N_REQ-1:0] ovf_q, ovf_d;
    logic [N_REQ-1:0] ack_clr;

    state_e           state_q, state_d;
    logic [N_REQ-1:0] a_q, a_d;
    logic             vin_q, vin_d;
    logic             grant_vld_q, grant_vld_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;

`ifdef PRI_REQ_SYNC_EN
    pri_req_sync #(
        .W (N_REQ)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (req),
        .q     (req_s)
    );
`else
    assign req_s = req;
`endif

    // Rising-edge detect; an ack clearing a line loses to a new edge on that line,
    // and only an edge on a line that stays pending counts as an overflow.
    always_comb begin
        edge_vec   = req_s & ~req_prev_q;
        req_prev_d = req_s;
        pending_d  = (pending_q & ~ack_clr) | edge_vec;
        ovf_d      = (ovf_clr ? '0 : ovf_q) | (edge_vec & pending_q & ~ack_clr);
    end

    // Request history, pending set and sticky overflow flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_prev_q <= '0;
            pending_q  <= '0;
            ovf_q      <= '0;
        end else begin
            req_prev_q <= req_prev_d;
            pending_q  <= pending_d;
            ovf_q      <= ovf_d;
        end
    end

    // Grant sequencing: snapshot, encoder handshake, then wait for ack or timeout.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        vin_d       = 1'b0;
        grant_vld_d = grant_vld_q;
        grant_idx_d = grant_idx_q;
        timeout_d   = 1'b0;
        cnt_d       = cnt_q;
        cnt_inc     = cnt_q + CNT_W'(1);
        ack_clr     = '0;
        unique case (state_q)
            IDLE: begin
                if ((pending_q & mask) != '0) begin
                    a_d     = pending_q & mask;
                    vin_d   = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                state_d = WAIT_ENC;
            end
            WAIT_ENC: begin
                // Encoder registered its answer on the PRESENT edge.
                grant_idx_d = idx;
                grant_vld_d = 1'b1;
                cnt_d       = '0;
                state_d     = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (ack) begin
                    ack_clr     = line_bit(grant_idx_q);
                    a_d         = '0;
                    grant_vld_d = 1'b0;
                    state_d     = IDLE;
                end else if (cnt_inc == TIMEOUT_VAL) begin
                    // Abandon the grant; the line stays pending and is re-offered.
                    cnt_d       = cnt_inc;
                    timeout_d   = 1'b1;
                    a_d         = '0;
                    grant_vld_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and its registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            vin_q       <= 1'b0;
            grant_vld_q <= 1'b0;
            grant_idx_q <= '0;
            timeout_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            vin_q       <= vin_d;
            grant_vld_q <= grant_vld_d;
            grant_idx_q <= grant_idx_d;
            timeout_q   <= timeout_d;
            cnt_q       <= cnt_d;
        end
    end

    assign a         = a_q;
    assign vin       = vin_q;
    assign grant_vld = grant_vld_q;
    assign grant_idx = grant_idx_q;
    assign timeout   = timeout_q;
    assign ovf       = ovf_q;

endmodule

// File: doc/pri_req_collector.md
PRI_REQ_COLLECTOR -- requirements
Module: pri_req_collector

Interface
REQ-001 Parameter ACK_TIMEOUT, default 255, SHALL set the maximum cycles spent in WAIT_ACK before abort; legal range 1..255.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req  input  8  raw request lines; rising edge = new request.
REQ-005 mask  input  8  per-line enable; masked lines stay pending but SHALL NOT be presented.
REQ-006 a  output  8  frozen snapshot of pending&mask, drives priority encoder a[7:0].
REQ-007 vin  output  1  encoder input-valid, high only in PRESENT.
REQ-008 idx  input  3  encoder out[2:0], registered by encoder one cycle after vin.
REQ-009 grant_vld  output  1  high in WAIT_ACK; grant_idx valid.
REQ-010 grant_idx  output  3  line index captured from idx.
REQ-011 ack  input  1  consumer acknowledges grant_idx serviced.
REQ-012 timeout  output  1  one-cycle pulse on ACK_TIMEOUT expiry.
REQ-013 ovf  output  8  sticky per-line overflow flags.
REQ-014 ovf_clr  input  1  clears all ovf bits.

Function
REQ-015 Edge detect: pending[i] SHALL set on the edge where req[i] samples 1 and its previous sample was 0.
REQ-016 Edge on a line already pending SHALL set ovf[i]; pending unchanged.
REQ-017 FSM states IDLE, PRESENT, WAIT_ENC, WAIT_ACK.
REQ-018 IDLE: if (pending&mask)!=0, SHALL load a <= pending&mask and go PRESENT; else stay.
REQ-019 PRESENT (1 cycle): vin=1, a held; next state WAIT_ENC.
REQ-020 WAIT_ENC (1 cycle): vin=0; SHALL capture grant_idx <= idx; next WAIT_ACK.
REQ-021 WAIT_ACK: grant_vld=1; on ack SHALL clear pending[grant_idx], clear a, return IDLE.
REQ-022 Timeout counter (8 bits) SHALL clear on WAIT_ACK entry, increment each WAIT_ACK cycle without ack; reaching ACK_TIMEOUT SHALL pulse timeout, keep pending, return IDLE.
REQ-023 Simultaneous ack clear and new edge on same line: set SHALL win, no ovf.
REQ-024 mask/req changes after PRESENT SHALL NOT alter a or grant_idx for the current grant.
REQ-025 ovf_clr coincident with new overflow event: set SHALL win.
REQ-026 Back-to-back: IDLE re-presents on the cycle after ack if anything remains pending.
REQ-027 Minimum request-to-grant_vld latency: 4 cycles (edge, IDLE, PRESENT, WAIT_ENC).

Reset
REQ-028 rst_n low SHALL force: state IDLE, pending=0, a=0, vin=0, grant_vld=0, grant_idx=0, timeout=0, ovf=0, counter=0, edge-history=0.
REQ-029 Reset mid-grant SHALL discard the grant silently; req held high through reset SHALL register as a new edge on the first sampled cycle.

Configuration
REQ-030 Macro PRI_REQ_SYNC_EN defined: req SHALL pass a 2-flop synchronizer (reset 0) before edge detect, adding 2 cycles latency; undefined: req feeds edge detect directly.

Structure
REQ-031 Shared package pri_enc_pkg SHALL hold N_REQ=8, IDX_W=3, and the FSM state enum.
REQ-032 Synchronizer SHALL be sub-module pri_req_sync (8-bit, 2-stage), instantiated only under PRI_REQ_SYNC_EN.

Verification
REQ-033 req=0x00->0x24 pulse, mask=0xFF, encoder model: a=0x24, vin one cycle, grant_idx=5; ack -> pending=0x04; second grant_idx=2.
REQ-034 req[3] edge while pending[3]=1 -> ovf=0x08; ovf_clr -> ovf=0x00; simultaneous edge+ovf_clr -> ovf=0x08.
REQ-035 ACK_TIMEOUT=4, no ack -> timeout pulse after 4 WAIT_ACK cycles, pending unchanged, new PRESENT follows.
REQ-036 mask=0x00 with pending=0x81 -> vin never asserts; mask->0x01 -> grant_idx=0.
REQ-037 rst_n low during WAIT_ACK -> all outputs 0 asynchronously; req held 0x10 -> pending=0x10 first cycle after release.
REQ-038 Ack on grant_idx=6 same cycle as req[6] edge -> pending[6] stays 1, ovf[6]=0.
